// File: rtl/requant_stream.sv
// Multi-lane Qm.n -> Qp.q requantizer: S1 rounds and shifts, S2 range-checks, clamps or wraps.
// Valid/ready on both sides, per-lane overflow flags and a saturating overflow-beat counter.
module requant_stream #(
    parameter int unsigned WIDTH_IN  = 32,
    parameter int unsigned FRAC_IN   = 16,
    parameter int unsigned WIDTH_OUT = 16,
    parameter int unsigned FRAC_OUT  = 8,
    parameter int unsigned LANES     = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*WIDTH_IN-1:0]  in_data,
    input  logic [1:0]                 round_mode,
    input  logic                       sat_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*WIDTH_OUT-1:0] out_data,
    output logic [LANES-1:0]           sat_flag,
    input  logic                       clear_count,
    output logic [CNT_W-1:0]           ovf_count
);

    localparam int unsigned SHIFT = FRAC_IN - FRAC_OUT;
    localparam int unsigned WX    = WIDTH_IN + 1;
    localparam logic signed [WX-1:0] MAXV = WX'((64'sd1 <<< (WIDTH_OUT - 1)) - 64'sd1);
    localparam logic signed [WX-1:0] MINV = ~MAXV;

    logic                       adv;
    logic signed [WX-1:0]       r_d [LANES];
    logic signed [WX-1:0]       s1_r_q [LANES];
    logic                       s1_valid_q;
    logic                       s1_sat_q;
    logic [LANES*WIDTH_OUT-1:0] out_data_d;
    logic [LANES-1:0]           sat_flag_d;
    logic [LANES*WIDTH_OUT-1:0] out_data_q;
    logic [LANES-1:0]           sat_flag_q;
    logic                       out_valid_q;
    logic [CNT_W-1:0]           ovf_count_q;

    // An empty output stage always advances, so bubbles collapse.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [WX-1:0] lane_x;
        assign lane_x = WX'($signed(in_data[i*WIDTH_IN +: WIDTH_IN]));

        if (SHIFT == 0) begin : g_pass
            assign r_d[i] = lane_x;
        end else begin : g_round
            logic [WX-1:0] bias;
            always_comb begin
                case (round_mode)
                    2'd1:    bias = WX'(1) << (SHIFT - 1);
                    // Half-even: one less than half, plus the LSB that survives the shift.
                    2'd2:    bias = (WX'(1) << (SHIFT - 1)) - WX'(1) + WX'(lane_x[SHIFT]);
                    default: bias = '0;
                endcase
            end
            assign r_d[i] = (lane_x + $signed(bias)) >>> SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sat_q   <= 1'b0;
            s1_r_q     <= '{default: '0};
        end else if (adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sat_q <= sat_en;
                s1_r_q   <= r_d;
            end
        end
    end

    logic signed [WX-1:0]  r_cur;
    logic [WIDTH_OUT-1:0]  lane_out;
    logic                  hi;
    logic                  lo;

    always_comb begin
        out_data_d = '0;
        sat_flag_d = '0;
        r_cur      = '0;
        lane_out   = '0;
        hi         = 1'b0;
        lo         = 1'b0;
        for (int i = 0; i < int'(LANES); i++) begin
            r_cur    = s1_r_q[i];
            hi       = r_cur > MAXV;
            lo       = r_cur < MINV;
            lane_out = r_cur[WIDTH_OUT-1:0];
            if (s1_sat_q && hi) begin
                lane_out = MAXV[WIDTH_OUT-1:0];
            end else if (s1_sat_q && lo) begin
                lane_out = MINV[WIDTH_OUT-1:0];
            end
            sat_flag_d[i] = hi | lo;
            out_data_d[i*WIDTH_OUT +: WIDTH_OUT] = lane_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_flag_q  <= '0;
        end else if (adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= out_data_d;
                sat_flag_q <= sat_flag_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_count) begin
            ovf_count_q <= '0;
        end else if (out_valid_q && out_ready && (|sat_flag_q) && (ovf_count_q != '1)) begin
            ovf_count_q <= ovf_count_q + CNT_W'(1);
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_flag  = sat_flag_q;
    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_requant_stream.sv
// Randomized and directed bench for requant_stream; a queue-based arithmetic model predicts
// every delivered beat and both overflow counters (CNT_W = 16 and a CNT_W = 2 instance).
module tb_requant_stream;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [1:0]   round_mode;
    logic         sat_en;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic [3:0]   sat_flag;
    logic         clear_count;
    logic [15:0]  ovf_count;

    logic         in_ready2;
    logic         out_valid2;
    logic [63:0]  out_data2;
    logic [3:0]   sat_flag2;
    logic [1:0]   ovf_count2;

    always #5 clk = ~clk;

    requant_stream dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .round_mode(round_mode), .sat_en(sat_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .sat_flag(sat_flag), .clear_count(clear_count),
        .ovf_count(ovf_count)
    );

    requant_stream #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .round_mode(round_mode), .sat_en(sat_en), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .sat_flag(sat_flag2), .clear_count(clear_count),
        .ovf_count(ovf_count2)
    );

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [63:0] exp_data_q[$];
    logic [3:0]  exp_flag_q[$];
    int          cnt_m = 0;
    int          cnt2_m = 0;
    int          delivered = 0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [3:0]  prev_flag;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Q16.16 -> Q8.8: value / 256 with the selected rounding, then range handling.
    function automatic void model_lane(input logic [31:0] v, input logic [1:0] m, input logic s,
                                       output logic [15:0] o, output logic f);
        longint x, q, rem, r;
        x   = longint'($signed(v));
        q   = x >>> 8;
        rem = x - q * 256;
        r   = q;
        if (m == 2'd1 && rem >= 128) r = q + 1;
        if (m == 2'd2 && (rem > 128 || (rem == 128 && (q % 2) != 0))) r = q + 1;
        f = (r > 32767) || (r < -32768);
        if (f && s) o = (r > 0) ? 16'h7FFF : 16'h8000;
        else        o = r[15:0];
    endfunction

    function automatic void model_beat(input logic [127:0] d, input logic [1:0] m, input logic s,
                                       output logic [63:0] o, output logic [3:0] f);
        logic [15:0] lo;
        logic        lf;
        o = '0;
        f = '0;
        for (int i = 0; i < 4; i++) begin
            model_lane(d[i*32 +: 32], m, s, lo, lf);
            o[i*16 +: 16] = lo;
            f[i]          = lf;
        end
    endfunction

    function automatic logic [31:0] rand_sample();
        int c;
        int v;
        c = int'($urandom % 4);
        case (c)
            0:       v = int'($urandom);
            1:       v = int'($urandom % (1 << 24)) - (1 << 23);
            2: begin
                v = (32767 << 8) + int'($urandom % 1024) - 512;
                if ($urandom % 2 == 1) v = -v;
            end
            default: v = (int'($urandom % 512) - 256) * 256 + 128;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin : monitor
        logic [63:0] md;
        logic [3:0]  mf;
        bit          hs_out;
        if (mon_en) begin
            check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            check("ovf_count", 64'(ovf_count), 64'(cnt_m));
            check("ovf_count_w2", 64'(ovf_count2), 64'(cnt2_m));
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", out_data, prev_data);
                check("stall_flag", 64'(sat_flag), 64'(prev_flag));
            end
            if (out_valid) begin
                if (exp_data_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_beat: got out_data %h, required no beat", out_data);
                end else begin
                    check("out_data", out_data, exp_data_q[0]);
                    check("sat_flag", 64'(sat_flag), 64'(exp_flag_q[0]));
                end
            end
            if (rst) begin
                exp_data_q.delete();
                exp_flag_q.delete();
                cnt_m      = 0;
                cnt2_m     = 0;
                prev_stall = 1'b0;
            end else begin
                hs_out = out_valid && out_ready && exp_data_q.size() > 0;
                if (clear_count) begin
                    cnt_m  = 0;
                    cnt2_m = 0;
                end else if (hs_out && |exp_flag_q[0]) begin
                    if (cnt_m < 65535) cnt_m++;
                    if (cnt2_m < 3) cnt2_m++;
                end
                if (hs_out) begin
                    void'(exp_data_q.pop_front());
                    void'(exp_flag_q.pop_front());
                    delivered++;
                end
                if (in_valid && in_ready) begin
                    model_beat(in_data, round_mode, sat_en, md, mf);
                    exp_data_q.push_back(md);
                    exp_flag_q.push_back(mf);
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_flag  = sat_flag;
            end
        end
    end

    task automatic directed(input string name, input logic [31:0] v, input logic [1:0] m,
                            input logic s, input logic [15:0] e, input logic ef);
        bit got;
        @(posedge clk); #1;
        in_valid   = 1'b1;
        in_data    = {4{v}};
        round_mode = m;
        sat_en     = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no out_valid, required one within 6 cycles", name);
        end else begin
            check(name, out_data, {4{e}});
            check({name, "_flag"}, 64'(sat_flag), 64'({4{ef}}));
        end
    endtask

    task automatic wait_out(input string name);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no out_valid, required one within 8 cycles", name);
        end
    endtask

    initial begin
        bit          acc;
        int          sent;
        int          d0;
        int          seen;
        logic [3:0]  pat;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        round_mode  = 2'd0;
        sat_en      = 1'b0;
        out_ready   = 1'b0;
        clear_count = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_sat_flag", 64'(sat_flag), 64'd0);
        check("rst_ovf_count", 64'(ovf_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        out_ready = 1'b1;
        directed("t1_m0", 32'h0001_8080, 2'd0, 1'b1, 16'h0180, 1'b0);
        directed("t1_m1", 32'h0001_8080, 2'd1, 1'b1, 16'h0181, 1'b0);
        directed("t1_m2", 32'h0001_8080, 2'd2, 1'b1, 16'h0180, 1'b0);
        directed("t1_m2_odd", 32'h0001_8180, 2'd2, 1'b1, 16'h0182, 1'b0);
        directed("t1_m3", 32'h0001_8080, 2'd3, 1'b1, 16'h0180, 1'b0);
        directed("t2_m0", 32'hFFFF_FF80, 2'd0, 1'b1, 16'hFFFF, 1'b0);
        directed("t2_m1", 32'hFFFF_FF80, 2'd1, 1'b1, 16'h0000, 1'b0);
        directed("t2_m2", 32'hFFFF_FF80, 2'd2, 1'b1, 16'h0000, 1'b0);
        directed("t3_sat_hi", 32'h0100_0000, 2'd0, 1'b1, 16'h7FFF, 1'b1);
        directed("t3_wrap_hi", 32'h0100_0000, 2'd0, 1'b0, 16'h0000, 1'b1);
        directed("t3_sat_lo", 32'h8000_0000, 2'd0, 1'b1, 16'h8000, 1'b1);
        directed("t3_round_ovf", 32'h007F_FF80, 2'd1, 1'b1, 16'h7FFF, 1'b1);

        // Counter: 5 overflows, saturation of the 2-bit instance, then clear racing a handshake.
        @(posedge clk); #1;
        clear_count = 1'b1;
        @(posedge clk); #1;
        clear_count = 1'b0;
        for (int i = 0; i < 4; i++) directed("t5_ovf", 32'h0100_0000, 2'd0, 1'b1, 16'h7FFF, 1'b1);
        @(negedge clk);
        check("t5_w2_hold", 64'(ovf_count2), 64'd3);
        directed("t5_ovf", 32'h0100_0000, 2'd0, 1'b1, 16'h7FFF, 1'b1);
        @(negedge clk);
        check("t5_count5", 64'(ovf_count), 64'd5);
        check("t5_w2_still", 64'(ovf_count2), 64'd3);
        @(posedge clk); #1;
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_data    = {4{32'h0100_0000}};
        round_mode = 2'd0;
        sat_en     = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out("t5_sixth");
        @(posedge clk); #1;
        out_ready   = 1'b1;
        clear_count = 1'b1;
        @(posedge clk); #1;
        clear_count = 1'b0;
        @(negedge clk);
        check("t5_clear_prio", 64'(ovf_count), 64'd0);
        check("t5_clear_prio_w2", 64'(ovf_count2), 64'd0);

        // Backpressure: out_ready pattern 1,0,0,1 while 8 beats stream in.
        pat  = 4'b1001;
        sent = 0;
        d0   = delivered;
        for (int cyc = 0; cyc < 200 && sent < 8; cyc++) begin
            @(posedge clk); #1;
            out_ready  = pat[cyc % 4];
            in_valid   = 1'b1;
            in_data    = {rand_sample(), rand_sample(), rand_sample(), 32'(sent * 4096)};
            round_mode = 2'($urandom);
            sat_en     = 1'($urandom);
            @(negedge clk);
            acc = in_ready;
            if (acc) sent++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("t4_delivered", 64'(delivered - d0), 64'd8);
        check("t4_drained", 64'(exp_data_q.size()), 64'd0);

        // Randomized traffic.
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            in_valid    = ($urandom % 10) < 7;
            in_data     = {rand_sample(), rand_sample(), rand_sample(), rand_sample()};
            round_mode  = 2'($urandom);
            sat_en      = 1'($urandom);
            out_ready   = ($urandom % 10) < 6;
            clear_count = ($urandom % 40) == 0;
        end
        @(posedge clk); #1;
        in_valid    = 1'b0;
        clear_count = 1'b0;
        out_ready   = 1'b1;
        repeat (6) @(negedge clk);
        check("rand_drained", 64'(exp_data_q.size()), 64'd0);

        // Reset with both stages full.
        directed("t6_pre", 32'h0100_0000, 2'd0, 1'b1, 16'h7FFF, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = {4{32'h0000_1234}};
        @(posedge clk); #1;
        in_data   = {4{32'h0000_5678}};
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_full_valid", 64'(out_valid), 64'd1);
        check("t6_full_ready", 64'(in_ready), 64'd0);
        check("t6_count_before", 64'(ovf_count != 16'd0), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_ovf_count", 64'(ovf_count), 64'd0);
        check("t6_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("t6_no_stale", 64'(seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
